mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, address width.
REQ-002 SHALL have parameter: DATA_W, 32, data width.
REQ-003 SHALL have parameter: MEM_LAT, 1, cycles from access issue to mem_rdata valid; legal range 1..4.
REQ-004 SHALL have port: clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port: if_req  in  1  fetch requester read request; held until if_ack.
REQ-007 SHALL have port: if_addr  in  ADDR_W  fetch address.
REQ-008 SHALL have port: if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port: if_rdata  out  DATA_W  fetch read data; valid while if_ack is high, held afterwards.
REQ-010 SHALL have port: d_req  in  1  data requester request; held until d_ack.
REQ-011 SHALL have port: d_we  in  1  data write enable; 1 = store, 0 = load.
REQ-012 SHALL have port: d_addr  in  ADDR_W  data address.
REQ-013 SHALL have port: d_wdata  in  DATA_W  store data.
REQ-014 SHALL have port: d_wmask  in  4  store byte enables.
REQ-015 SHALL have port: d_ack  out  1  one-cycle data completion pulse.
REQ-016 SHALL have port: d_rdata  out  DATA_W  load data; valid while d_ack is high, held afterwards.
REQ-017 SHALL have port: mem_addr  out  ADDR_W  shared memory address.
REQ-018 SHALL have port: mem_we  out  1  shared memory write strobe.
REQ-019 SHALL have port: mem_wdata  out  DATA_W  shared memory write data.
REQ-020 SHALL have port: mem_wmask  out  4  shared memory byte enables.
REQ-021 SHALL have port: mem_rdata  in  DATA_W  shared memory read data.
REQ-022 SHALL have port: busy  out  1  high in every state other than IDLE.
REQ-023 SHALL have port: grant_id  out  1  owner of the current transaction (0 = fetch, 1 = data); meaningful only while busy.

Function
REQ-024 SHALL implement FSM states IDLE, ACCESS, ACK.
- IDLE -> ACCESS on any sampled request.
- ACCESS -> ACK after MEM_LAT cycles in ACCESS.
- ACK -> IDLE unconditionally.
REQ-025 SHALL sample if_req and d_req only in IDLE; requests in ACCESS and ACK are ignored.
REQ-026 SHALL arbitrate contention in IDLE round-robin:
- The winner is the port not granted last.
- last_grant resets to data, so fetch wins the first conflict.
- An uncontested request wins regardless of last_grant.
REQ-027 SHALL latch the winner's addr, we, wdata and wmask on the IDLE->ACCESS edge; inputs may change afterwards. Fetch latches we=0 and wmask=0.
REQ-028 SHALL drive mem_addr, mem_wdata and mem_wmask from the latched values throughout ACCESS.
REQ-029 SHALL assert mem_we only in the first ACCESS cycle of a store, for exactly one cycle.
REQ-030 SHALL use a 3-bit down-counter, loaded with MEM_LAT-1 on entry to ACCESS, to time ACCESS.
REQ-031 SHALL capture mem_rdata into the owner's rdata register at the end of the last ACCESS cycle.
REQ-032 SHALL assert exactly one of if_ack/d_ack, for the owner, during ACK, and never both together.
REQ-033 SHALL, for a request sampled in cycle N, assert ack in cycle N+MEM_LAT+1.
REQ-034 SHALL complete stores through the same latency; d_rdata is still updated with mem_rdata.
REQ-035 SHALL treat a request still high in the IDLE cycle after ACK as a new transaction. Requesters drop req on the edge where they sample ack.
REQ-036 SHALL, in IDLE, drive mem_we=0 and mem_wmask=0; mem_addr holds its last value.
REQ-037 SHALL pass addresses through unmodified; alignment is not checked, and a store with wmask=0 completes normally.

Reset
REQ-038 SHALL, while reset is high, asynchronously force:
- state = IDLE, counter = 0, last_grant = data;
- if_ack = d_ack = mem_we = busy = grant_id = 0;
- mem_wmask = 0, mem_addr = 0, mem_wdata = 0, if_rdata = 0, d_rdata = 0.
REQ-039 SHALL, on reset during ACCESS or ACK, abort the transaction with no ack. mem_we falls the same instant reset rises.

Verification
REQ-040 Fetch read, MEM_LAT=1: if_req at cycle 0, if_addr=0x10, mem returns 0x00500093 -> mem_addr=0x10 in cycle 1, if_ack only in cycle 2 with if_rdata=0x00500093, mem_we=0 throughout.
REQ-041 Store, MEM_LAT=1: d_req/d_we at cycle 0, d_addr=0x100, d_wdata=0xDEADBEEF, d_wmask=0xF -> mem_we high only in cycle 1 with those values, d_ack in cycle 2, if_ack never.
REQ-042 Contention: both req held continuously after reset -> grant_id sequence 0,1,0,1; acks alternate if_ack, d_ack; ack cycles spaced MEM_LAT+2 apart.
REQ-043 Latency, MEM_LAT=3: d_req load at cycle 0 -> busy cycles 1-4, ack in cycle 4, d_rdata equals mem_rdata sampled at end of cycle 3.
REQ-044 Reset mid-store: reset pulsed during the first ACCESS cycle -> mem_we drops immediately, no d_ack, busy=0; re-issued store then completes normally.
REQ-045 Held request: if_req left high through ACK -> second transaction's ACCESS starts 2 cycles after the first if_ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// Fetch/data round-robin arbiter onto a single shared memory port. A request sampled in IDLE is acked
// MEM_LAT+1 cycles later. The losing requester simply holds its request; nothing is queued.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wmask,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;
    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              win;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        // On contention the port that did not win last time goes; a lone request always wins.
        win        = (if_req && d_req) ? ~last_q : d_req;
        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_INIT;
                    owner_d = win;
                    last_d  = win;
                    addr_d  = win ? d_addr : if_addr;
                    we_d    = win & d_we;
                    wdata_d = win ? d_wdata : '0;
                    wmask_d = win ? d_wmask : 4'h0;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_ACK;
                    if (owner_q) d_rdata_d  = mem_rdata;
                    else         if_rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= 4'h0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Outputs decode straight from state so reset drops mem_we and the acks without waiting for an edge.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = (state_q == S_ACCESS) ? wmask_q : 4'h0;
    assign mem_we    = (state_q == S_ACCESS) && we_q && (cnt_q == CNT_INIT);
    assign busy      = (state_q != S_IDLE);
    assign grant_id  = owner_q;
    assign if_ack    = (state_q == S_ACK) && !owner_q;
    assign d_ack     = (state_q == S_ACK) && owner_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized fetch/data requesters against mem_arbiter at MEM_LAT 1 and 3, scoreboarded by a transaction-level model.
module tb_mem_arbiter;
    localparam int NTXN = 30;

    typedef struct {
        bit          port;
        int          s;
        int          ack;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
    } txn_t;

    int n_chk  = 0;
    int n_fail = 0;
    bit done [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents as a fixed function of address, so any captured word is predictable.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'h00500093;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        clk = 1'b0;
        logic        reset;
        logic        if_req, if_ack, d_req, d_we, d_ack, mem_we, busy, grant_id;
        logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
        logic [3:0]  d_wmask, mem_wmask;

        int          cyc = 0;
        bit          model_en = 1'b0;
        bit          go = 1'b0;
        bit          fdone = 1'b0;
        bit          ddone = 1'b0;
        int          free_at = 0;
        bit          last_own = 1'b1;
        logic [31:0] exp_if = '0;
        logic [31:0] exp_d = '0;
        txn_t        exp_q[$];

        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
            .clk(clk), .reset(reset),
            .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
            .d_ack(d_ack), .d_rdata(d_rdata),
            .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
            .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
        );

        always #5 clk = ~clk;
        assign mem_rdata = mem_fn(mem_addr);
        always @(posedge clk) cyc <= cyc + 1;

        // Reference: the arbiter is free from free_at on; a request seen then starts a transaction.
        always @(negedge clk) begin : model
            txn_t n;
            if (model_en && cyc >= free_at && (if_req || d_req)) begin
                n.port  = (if_req && d_req) ? ~last_own : d_req;
                n.s     = cyc;
                n.ack   = cyc + LAT + 1;
                n.addr  = n.port ? d_addr : if_addr;
                n.we    = n.port & d_we;
                n.wdata = d_wdata;
                n.wmask = n.port ? d_wmask : 4'h0;
                n.rdata = mem_fn(n.addr);
                exp_q.push_back(n);
                last_own = n.port;
                free_at  = cyc + LAT + 2;
            end
        end

        always @(negedge clk) begin : mon
            txn_t t;
            bit   act;
            if (model_en) begin
                act = (exp_q.size() > 0) && (cyc > exp_q[0].s);
                if (act) t = exp_q[0];
                chk("busy", 64'(busy), 64'(act));
                if (act) begin
                    chk("grant_id", 64'(grant_id), 64'(t.port));
                    if (cyc <= t.s + LAT) begin
                        chk("mem_addr", 64'(mem_addr), 64'(t.addr));
                        chk("mem_we", 64'(mem_we), 64'(t.we && cyc == t.s + 1));
                        chk("mem_wmask", 64'(mem_wmask), 64'(t.wmask));
                        if (t.we && cyc == t.s + 1) chk("mem_wdata", 64'(mem_wdata), 64'(t.wdata));
                    end
                end else begin
                    chk("idle_mem_we", 64'(mem_we), 64'd0);
                    chk("idle_mem_wmask", 64'(mem_wmask), 64'd0);
                end
                if (if_ack || d_ack) begin
                    if (!act) begin
                        chk("spurious_ack", 64'({if_ack, d_ack}), 64'd0);
                    end else begin
                        chk("ack_port", 64'({if_ack, d_ack}), t.port ? 64'd1 : 64'd2);
                        chk("ack_cycle", 64'(cyc), 64'(t.ack));
                        if (t.port) exp_d = t.rdata;
                        else        exp_if = t.rdata;
                        exp_q.delete(0);
                    end
                end else if (act && cyc >= t.ack) begin
                    chk("ack_missing", 64'({if_ack, d_ack}), t.port ? 64'd1 : 64'd2);
                    if (t.port) exp_d = t.rdata;
                    else        exp_if = t.rdata;
                    exp_q.delete(0);
                end
                chk("if_rdata", 64'(if_rdata), 64'(exp_if));
                chk("d_rdata", 64'(d_rdata), 64'(exp_d));
            end
        end

        initial begin : fetch_gen
            int gap;
            int k;
            wait (go);
            for (int i = 0; i < NTXN; i++) begin
                gap = (i == 0 || $urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 3));
                if (gap > 0) begin
                    if_req = 1'b0;
                    repeat (gap) @(posedge clk);
                    #1;
                end
                if_req  = 1'b1;
                if_addr = (i == 0) ? 32'h10 : $urandom;
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!if_ack && k < 64);
                if (!if_ack) chk("if_ack_wait", 64'(if_ack), 64'd1);
                @(posedge clk);
                #1;
            end
            if_req = 1'b0;
            fdone  = 1'b1;
        end

        initial begin : data_gen
            int gap;
            int k;
            wait (go);
            for (int i = 0; i < NTXN; i++) begin
                gap = (i == 0 || $urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 3));
                if (gap > 0) begin
                    d_req = 1'b0;
                    repeat (gap) @(posedge clk);
                    #1;
                end
                d_req   = 1'b1;
                d_we    = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                d_addr  = (i == 0) ? 32'h100 : $urandom;
                d_wdata = (i == 0) ? 32'hDEADBEEF : $urandom;
                d_wmask = (i == 0) ? 4'hF : 4'($urandom_range(0, 15));
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!d_ack && k < 64);
                if (!d_ack) chk("d_ack_wait", 64'(d_ack), 64'd1);
                @(posedge clk);
                #1;
            end
            d_req = 1'b0;
            ddone = 1'b1;
        end

        initial begin : main
            int k;
            reset = 1'b1;
            if_req = 1'b0; if_addr = '0;
            d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = 4'h0;
            repeat (2) @(negedge clk);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_acks", 64'({if_ack, d_ack}), 64'd0);
            chk("rst_mem_we", 64'(mem_we), 64'd0);
            chk("rst_grant_id", 64'(grant_id), 64'd0);
            chk("rst_mem_addr", 64'(mem_addr), 64'd0);
            chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
            chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
            chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
            @(posedge clk); #1;
            reset = 1'b0;
            // Store aborted by reset in its first ACCESS cycle.
            @(posedge clk); #1;
            d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wmask = 4'hF;
            @(posedge clk); #2;
            chk("abort_pre_we", 64'(mem_we), 64'd1);
            reset = 1'b1;
            #1;
            chk("abort_we", 64'(mem_we), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            d_req = 1'b0; d_we = 1'b0;
            repeat (LAT + 2) begin
                @(negedge clk);
                chk("abort_no_ack", 64'({if_ack, d_ack}), 64'd0);
                chk("abort_d_rdata", 64'(d_rdata), 64'd0);
            end
            @(posedge clk); #1;
            reset    = 1'b0;
            free_at  = 0;
            last_own = 1'b1;
            exp_if   = '0;
            exp_d    = '0;
            model_en = 1'b1;
            go       = 1'b1;
            k = 0;
            while (!(fdone && ddone) && k < 20000) begin
                @(negedge clk);
                k++;
            end
            repeat (LAT + 3) @(negedge clk);
            chk("gen_done", 64'({fdone, ddone}), 64'd3);
            chk("queue_drained", 64'(exp_q.size()), 64'd0);
            @(posedge clk); #1;
            model_en = 1'b0;
            done[g]  = 1'b1;
        end
    end

    initial begin
        fork
            wait (done[0] && done[1]);
            #2000000;
        join_any
        if (!(done[0] && done[1])) chk("sim_timeout", 64'({done[0], done[1]}), 64'd3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
